// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
// State and owner encodings plus default timing constants.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// slave is the arbiter view; master is the requester/memory view.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic        stall_if;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    output stall_if
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output m_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    input  stall_if
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM stage.
// Data wins by default; a starved fetch is promoted after STARVE_MAX.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [LAT_W-1:0]    LAT_INIT = lat_load(MEM_LAT);
  localparam logic [STARVE_W-1:0] STV_LIM  = STARVE_W'(STARVE_MAX);

  state_t              state_q;
  state_t              state_d;
  owner_t              owner_q;
  owner_t              owner_d;
  logic [LAT_W-1:0]    lat_q;
  logic [LAT_W-1:0]    lat_d;
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  logic starved;
  logic pick_if;
  logic pick_d;
  logic rv_if;
  logic rv_d;
  logic gnt_if;
  logic gnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    pick_if = 1'b0;
    pick_d  = 1'b0;
    rv_if   = 1'b0;
    rv_d    = 1'b0;
    starved = (starve_q == STV_LIM);
    unique case (state_q)
      IDLE: begin
        pick_if = bus.if_req &&
                  (!bus.d_req || starved);
        pick_d  = bus.d_req && !pick_if;
        if (pick_if) begin
          state_d = RD_WAIT;
          owner_d = OWN_IF;
          lat_d   = LAT_INIT;
        end else if (pick_d && !bus.d_we) begin
          state_d = RD_WAIT;
          owner_d = OWN_D;
          lat_d   = LAT_INIT;
        end
      end
      RD_WAIT: begin
        // no grants here, even in the rvalid cycle
        if (lat_q == '0) begin
          rv_if   = (owner_q == OWN_IF);
          rv_d    = (owner_q == OWN_D);
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || pick_if) begin
      starve_d = '0;
    end else if (starve_q != STV_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // outputs are forced quiet while reset is asserted
  assign gnt_if = rst_n && pick_if;
  assign gnt_d  = rst_n && pick_d;

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.if_rvalid = rst_n && rv_if;
  assign bus.d_rvalid  = rst_n && rv_d;
  assign bus.if_rdata  = (rst_n && rv_if) ?
                         bus.m_rdata : '0;
  assign bus.d_rdata   = (rst_n && rv_d) ?
                         bus.m_rdata : '0;
  assign bus.stall_if  = rst_n && bus.if_req &&
                         !pick_if;

  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    unique case (1'b1)
      gnt_d: begin
        bus.m_en    = 1'b1;
        bus.m_we    = bus.d_we;
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
      end
      gnt_if: begin
        bus.m_en   = 1'b1;
        bus.m_addr = bus.if_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter across three parameter sets.
// Memory model returns addr ^ 0xA5A50000 for the last read strobe.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter_if b1 ();
  mem_arbiter_if b3 ();
  mem_arbiter_if bs ();

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));
  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) us (
    .clk(clk), .rst_n(rst_n), .bus(bs));

  logic [31:0] la1 = '0;
  logic [31:0] la3 = '0;
  logic [31:0] las = '0;

  always @(posedge clk) begin
    if (b1.m_en && !b1.m_we) la1 <= b1.m_addr;
    if (b3.m_en && !b3.m_we) la3 <= b3.m_addr;
    if (bs.m_en && !bs.m_we) las <= bs.m_addr;
  end

  assign b1.m_rdata = la1 ^ 32'hA5A5_0000;
  assign b3.m_rdata = la3 ^ 32'hA5A5_0000;
  assign bs.m_rdata = las ^ 32'hA5A5_0000;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0;
    b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0;
    b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
    bs.if_req = 0; bs.if_addr = 0; bs.d_req = 0;
    bs.d_we = 0; bs.d_addr = 0; bs.d_wdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_all();
    nxt();
    b1.if_req = 1; b1.if_addr = 32'h10;
    b1.d_req = 1; b1.d_we = 1;
    b1.d_addr = 32'h44; b1.d_wdata = 32'h55;
    #1;
    total_cnt++; if (b1.if_gnt !== 1'b0) $display("FAIL rst_if_gnt got=%b exp=0", b1.if_gnt); else pass_cnt++;
    total_cnt++; if (b1.d_gnt !== 1'b0) $display("FAIL rst_d_gnt got=%b exp=0", b1.d_gnt); else pass_cnt++;
    total_cnt++; if (b1.m_en !== 1'b0) $display("FAIL rst_m_en got=%b exp=0", b1.m_en); else pass_cnt++;
    total_cnt++; if (b1.m_we !== 1'b0) $display("FAIL rst_m_we got=%b exp=0", b1.m_we); else pass_cnt++;
    total_cnt++; if (b1.m_addr !== 32'h0) $display("FAIL rst_m_addr got=%h exp=0", b1.m_addr); else pass_cnt++;
    total_cnt++; if (b1.m_wdata !== 32'h0) $display("FAIL rst_m_wdata got=%h exp=0", b1.m_wdata); else pass_cnt++;
    total_cnt++; if (b1.stall_if !== 1'b0) $display("FAIL rst_stall got=%b exp=0", b1.stall_if); else pass_cnt++;
    total_cnt++; if (b1.if_rvalid !== 1'b0) $display("FAIL rst_if_rvalid got=%b exp=0", b1.if_rvalid); else pass_cnt++;
    idle_all();
    nxt();
    rst_n = 1;
    nxt();
    #1;
    total_cnt++; if (b1.m_en !== 1'b0) $display("FAIL idle_m_en got=%b exp=0", b1.m_en); else pass_cnt++;
    total_cnt++; if (b1.m_addr !== 32'h0) $display("FAIL idle_m_addr got=%h exp=0", b1.m_addr); else pass_cnt++;
  endtask

  task automatic test_fetch();
    nxt();
    b1.if_req = 1; b1.if_addr = 32'h10;
    #1;
    total_cnt++; if (b1.if_gnt !== 1'b1) $display("FAIL fetch_gnt got=%b exp=1", b1.if_gnt); else pass_cnt++;
    total_cnt++; if (b1.m_en !== 1'b1) $display("FAIL fetch_m_en got=%b exp=1", b1.m_en); else pass_cnt++;
    total_cnt++; if (b1.m_addr !== 32'h10) $display("FAIL fetch_m_addr got=%h exp=10", b1.m_addr); else pass_cnt++;
    total_cnt++; if (b1.m_we !== 1'b0) $display("FAIL fetch_m_we got=%b exp=0", b1.m_we); else pass_cnt++;
    total_cnt++; if (b1.stall_if !== 1'b0) $display("FAIL fetch_stall got=%b exp=0", b1.stall_if); else pass_cnt++;
    nxt();
    b1.if_req = 0;
    #1;
    total_cnt++; if (b1.if_rvalid !== 1'b1) $display("FAIL fetch_rvalid got=%b exp=1", b1.if_rvalid); else pass_cnt++;
    total_cnt++; if (b1.if_rdata !== 32'hA5A5_0010) $display("FAIL fetch_rdata got=%h exp=a5a50010", b1.if_rdata); else pass_cnt++;
    total_cnt++; if (b1.m_en !== 1'b0) $display("FAIL fetch_wait_m_en got=%b exp=0", b1.m_en); else pass_cnt++;
    nxt();
    #1;
    total_cnt++; if (b1.if_rvalid !== 1'b0) $display("FAIL fetch_pulse got=%b exp=0", b1.if_rvalid); else pass_cnt++;
    total_cnt++; if (b1.if_rdata !== 32'h0) $display("FAIL fetch_rdata_idle got=%h exp=0", b1.if_rdata); else pass_cnt++;
  endtask

  task automatic test_priority();
    nxt();
    b1.if_req = 1; b1.if_addr = 32'h40;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h100;
    #1;
    total_cnt++; if (b1.d_gnt !== 1'b1) $display("FAIL prio_d_gnt got=%b exp=1", b1.d_gnt); else pass_cnt++;
    total_cnt++; if (b1.if_gnt !== 1'b0) $display("FAIL prio_if_gnt got=%b exp=0", b1.if_gnt); else pass_cnt++;
    total_cnt++; if (b1.stall_if !== 1'b1) $display("FAIL prio_stall got=%b exp=1", b1.stall_if); else pass_cnt++;
    total_cnt++; if (b1.m_addr !== 32'h100) $display("FAIL prio_m_addr got=%h exp=100", b1.m_addr); else pass_cnt++;
    nxt();
    b1.d_req = 0;
    #1;
    total_cnt++; if (b1.d_rvalid !== 1'b1) $display("FAIL prio_d_rvalid got=%b exp=1", b1.d_rvalid); else pass_cnt++;
    total_cnt++; if (b1.d_rdata !== 32'hA5A5_0100) $display("FAIL prio_d_rdata got=%h exp=a5a50100", b1.d_rdata); else pass_cnt++;
    total_cnt++; if (b1.if_gnt !== 1'b0) $display("FAIL prio_rv_if_gnt got=%b exp=0", b1.if_gnt); else pass_cnt++;
    nxt();
    #1;
    total_cnt++; if (b1.if_gnt !== 1'b1) $display("FAIL prio_late_gnt got=%b exp=1", b1.if_gnt); else pass_cnt++;
    total_cnt++; if (b1.m_addr !== 32'h40) $display("FAIL prio_late_addr got=%h exp=40", b1.m_addr); else pass_cnt++;
    nxt();
    b1.if_req = 0;
    #1;
    total_cnt++; if (b1.if_rdata !== 32'hA5A5_0040) $display("FAIL prio_if_rdata got=%h exp=a5a50040", b1.if_rdata); else pass_cnt++;
  endtask

  task automatic test_store();
    nxt();
    b1.d_req = 1; b1.d_we = 1;
    b1.d_addr = 32'h20; b1.d_wdata = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (b1.d_gnt !== 1'b1) $display("FAIL st_gnt got=%b exp=1", b1.d_gnt); else pass_cnt++;
    total_cnt++; if (b1.m_en !== 1'b1) $display("FAIL st_m_en got=%b exp=1", b1.m_en); else pass_cnt++;
    total_cnt++; if (b1.m_we !== 1'b1) $display("FAIL st_m_we got=%b exp=1", b1.m_we); else pass_cnt++;
    total_cnt++; if (b1.m_addr !== 32'h20) $display("FAIL st_m_addr got=%h exp=20", b1.m_addr); else pass_cnt++;
    total_cnt++; if (b1.m_wdata !== 32'hDEAD_BEEF) $display("FAIL st_m_wdata got=%h exp=deadbeef", b1.m_wdata); else pass_cnt++;
    nxt();
    b1.d_req = 0; b1.d_we = 0; b1.d_wdata = 0;
    b1.if_req = 1; b1.if_addr = 32'h30;
    #1;
    total_cnt++; if (b1.d_rvalid !== 1'b0) $display("FAIL st_no_rvalid got=%b exp=0", b1.d_rvalid); else pass_cnt++;
    total_cnt++; if (b1.if_gnt !== 1'b1) $display("FAIL st_next_fetch got=%b exp=1", b1.if_gnt); else pass_cnt++;
    total_cnt++; if (b1.m_wdata !== 32'h0) $display("FAIL st_fetch_wdata got=%h exp=0", b1.m_wdata); else pass_cnt++;
    nxt();
    b1.if_req = 0;
    #1;
    total_cnt++; if (b1.if_rvalid !== 1'b1) $display("FAIL st_fetch_rv got=%b exp=1", b1.if_rvalid); else pass_cnt++;
    nxt();
    #1;
    total_cnt++; if (b1.m_en !== 1'b0) $display("FAIL st_idle_m_en got=%b exp=0", b1.m_en); else pass_cnt++;
  endtask

  task automatic test_starve();
    nxt();
    bs.d_req = 1; bs.d_we = 1;
    bs.d_addr = 32'h50; bs.d_wdata = 32'h1;
    bs.if_req = 1; bs.if_addr = 32'h60;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++; if (bs.d_gnt !== 1'b1) $display("FAIL stv_d_gnt%0d got=%b exp=1", i, bs.d_gnt); else pass_cnt++;
      total_cnt++; if (bs.if_gnt !== 1'b0) $display("FAIL stv_if_den%0d got=%b exp=0", i, bs.if_gnt); else pass_cnt++;
      nxt();
    end
    #1;
    total_cnt++; if (bs.if_gnt !== 1'b1) $display("FAIL stv_forced got=%b exp=1", bs.if_gnt); else pass_cnt++;
    total_cnt++; if (bs.d_gnt !== 1'b0) $display("FAIL stv_d_held got=%b exp=0", bs.d_gnt); else pass_cnt++;
    total_cnt++; if (bs.m_addr !== 32'h60) $display("FAIL stv_m_addr got=%h exp=60", bs.m_addr); else pass_cnt++;
    total_cnt++; if (bs.m_we !== 1'b0) $display("FAIL stv_m_we got=%b exp=0", bs.m_we); else pass_cnt++;
    nxt();
    bs.if_addr = 32'h70;
    #1;
    total_cnt++; if (bs.if_rdata !== 32'hA5A5_0060) $display("FAIL stv_rdata got=%h exp=a5a50060", bs.if_rdata); else pass_cnt++;
    total_cnt++; if (bs.d_gnt !== 1'b0) $display("FAIL stv_rv_no_gnt got=%b exp=0", bs.d_gnt); else pass_cnt++;
    nxt();
    #1;
    total_cnt++; if (bs.d_gnt !== 1'b1) $display("FAIL stv_cleared got=%b exp=1", bs.d_gnt); else pass_cnt++;
    nxt();
    #1;
    total_cnt++; if (bs.if_gnt !== 1'b1) $display("FAIL stv_again got=%b exp=1", bs.if_gnt); else pass_cnt++;
    nxt();
    bs.d_req = 0; bs.d_we = 0; bs.if_req = 0;
    #1;
    total_cnt++; if (bs.if_rdata !== 32'hA5A5_0070) $display("FAIL stv_rdata2 got=%h exp=a5a50070", bs.if_rdata); else pass_cnt++;
    nxt();
  endtask

  task automatic test_latency();
    nxt();
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h200;
    b3.if_req = 1; b3.if_addr = 32'h80;
    #1;
    total_cnt++; if (b3.d_gnt !== 1'b1) $display("FAIL lat_d_gnt got=%b exp=1", b3.d_gnt); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      b3.d_req = 0;
      #1;
      total_cnt++; if (b3.if_gnt !== 1'b0) $display("FAIL lat_no_gnt_t%0d got=%b exp=0", k, b3.if_gnt); else pass_cnt++;
      total_cnt++; if (b3.d_rvalid !== (k == 3)) $display("FAIL lat_rvalid_t%0d got=%b exp=%b", k, b3.d_rvalid, (k == 3)); else pass_cnt++;
    end
    total_cnt++; if (b3.d_rdata !== 32'hA5A5_0200) $display("FAIL lat_d_rdata got=%h exp=a5a50200", b3.d_rdata); else pass_cnt++;
    nxt();
    #1;
    total_cnt++; if (b3.if_gnt !== 1'b1) $display("FAIL lat_if_gnt_t4 got=%b exp=1", b3.if_gnt); else pass_cnt++;
    nxt();
    b3.if_req = 0;
    nxt();
    nxt();
    #1;
    total_cnt++; if (b3.if_rdata !== 32'hA5A5_0080) $display("FAIL lat_if_rdata got=%h exp=a5a50080", b3.if_rdata); else pass_cnt++;
    nxt();
  endtask

  task automatic test_reset_rdwait();
    int seen;
    seen = 0;
    nxt();
    b3.if_req = 1; b3.if_addr = 32'h90;
    #1;
    total_cnt++; if (b3.if_gnt !== 1'b1) $display("FAIL rrw_gnt got=%b exp=1", b3.if_gnt); else pass_cnt++;
    nxt();
    b3.if_req = 0;
    rst_n = 0;
    #1;
    total_cnt++; if (b3.if_rvalid !== 1'b0) $display("FAIL rrw_rvalid got=%b exp=0", b3.if_rvalid); else pass_cnt++;
    total_cnt++; if (b3.m_en !== 1'b0) $display("FAIL rrw_m_en got=%b exp=0", b3.m_en); else pass_cnt++;
    nxt();
    nxt();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (b3.if_rvalid !== 1'b0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL rrw_ghost_rvalid got=%0d exp=0", seen); else pass_cnt++;
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h300;
    #1;
    total_cnt++; if (b3.d_gnt !== 1'b1) $display("FAIL rrw_post_gnt got=%b exp=1", b3.d_gnt); else pass_cnt++;
    total_cnt++; if (b3.m_addr !== 32'h300) $display("FAIL rrw_post_addr got=%h exp=300", b3.m_addr); else pass_cnt++;
    nxt();
    b3.d_req = 0;
    nxt();
    nxt();
    #1;
    total_cnt++; if (b3.d_rdata !== 32'hA5A5_0300) $display("FAIL rrw_post_rdata got=%h exp=a5a50300", b3.d_rdata); else pass_cnt++;
    nxt();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_starve();
    test_latency();
    test_reset_rdwait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: read latency of the shared memory in cycles, legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 4: consecutive denied fetch cycles before fetch gets forced priority, legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 if_req  in  1  fetch stage requests an instruction read.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  if_rdata valid this cycle.
REQ-009 if_rdata  out  32  fetched instruction word.
REQ-010 d_req  in  1  MEM stage requests a data access.
REQ-011 d_we  in  1  1 = store, 0 = load; qualified by d_req.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  data request accepted this cycle.
REQ-015 d_rvalid  out  1  d_rdata valid this cycle; loads only.
REQ-016 d_rdata  out  32  load data.
REQ-017 m_en  out  1  memory access strobe.
REQ-018 m_we  out  1  memory write enable.
REQ-019 m_addr  out  32  memory address.
REQ-020 m_wdata  out  32  memory write data.
REQ-021 m_rdata  in  32  memory read data, valid MEM_LAT cycles after a read strobe.
REQ-022 stall_if  out  1  high whenever if_req is high and if_gnt is low.

Function
REQ-023 FSM states: IDLE (port free) and RD_WAIT (read outstanding); only one access is in flight at a time.
REQ-024 In IDLE, when at least one request is present, exactly one requester is granted, in the same cycle, combinationally.
REQ-025 Default priority: d_req beats if_req.
REQ-026 Exception: if starve_cnt == STARVE_MAX, if_req beats d_req.
REQ-027 On grant: m_en=1, m_addr/m_we/m_wdata = granted requester's values; for fetch, m_we=0 and m_wdata=0.
REQ-028 Store grant: completes in the grant cycle; FSM stays in IDLE; no d_rvalid.
REQ-029 Read grant (fetch or load): FSM enters RD_WAIT, latches the owner, and loads lat_cnt=MEM_LAT-1.
REQ-030 RD_WAIT: lat_cnt decrements each cycle; in the cycle lat_cnt==0, owner's rvalid=1 and rdata=m_rdata; FSM returns to IDLE on the next edge.
REQ-031 RD_WAIT never grants, even in the rvalid cycle; the earliest next grant is the cycle after rvalid.
REQ-032 Outside its rvalid cycle, each rdata output is 0; rvalid is a single-cycle pulse.
REQ-033 starve_cnt (4-bit): increments, saturating at STARVE_MAX, in each cycle with if_req=1 and if_gnt=0; clears on if_gnt or when if_req=0.
REQ-034 With no request in IDLE, all m_* outputs are 0.
REQ-035 Requesters hold req/addr/data stable until gnt; the arbiter does not latch ungranted requests.

Reset
REQ-036 When rst_n=0 at an edge: FSM=IDLE, lat_cnt=0, starve_cnt=0, owner=fetch.
REQ-037 While rst_n=0: all outputs are 0 (gnt, rvalid, rdata, m_*, stall_if).
REQ-038 Reset during RD_WAIT abandons the read; no rvalid is produced for it after reset releases.

Structure
REQ-039 Shared package holds: state encoding (IDLE=0, RD_WAIT=1), owner encoding (OWN_IF=0, OWN_D=1), and the default MEM_LAT/STARVE_MAX constants.
REQ-040 Single module; the starvation counter is inline logic, not a separate sub-module.

Verification
REQ-041 MEM_LAT=1, reset released, if_req=1 at if_addr=0x10 only -> if_gnt same cycle, m_addr=0x10, m_we=0, if_rvalid next cycle with the memory word; stall_if=0 in the grant cycle.
REQ-042 if_req and d_req (load at 0x100) in the same cycle -> d_gnt=1, if_gnt=0, stall_if=1; d_rvalid one cycle later; if_gnt in the following cycle.
REQ-043 STARVE_MAX=2; d_req held with back-to-back stores, if_req held -> if denied 2 cycles, then if_gnt=1 and d_gnt=0 in cycle 3; starve_cnt returns to 0.
REQ-044 MEM_LAT=3, load granted at cycle t -> d_rvalid only at cycle t+3; no grants at t+1..t+3 despite pending if_req; if_gnt at t+4.
REQ-045 Store d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> m_en=m_we=1 with matching addr/data for one cycle; no d_rvalid; a fetch is grantable the next cycle.
REQ-046 rst_n driven low during RD_WAIT (MEM_LAT=3) -> all outputs 0, no rvalid after release, FSM in IDLE granting on the first post-reset request.
